// File: rtl/apply_move_if.sv
// rtl/apply_move_if.sv - move request / board response bundle for apply_move
interface apply_move_if;
  logic         start;
  logic [2:0]   x;
  logic [2:0]   y;
  logic         player_black;
  logic [7:0]   valids;
  logic [47:0]  end_points;
  logic [127:0] board_in;
  logic [127:0] board_out;
  logic         busy;
  logic         done;
  logic         illegal;
  logic [5:0]   flip_count;

  modport master (
    output start, x, y, player_black, valids, end_points, board_in,
    input  board_out, busy, done, illegal, flip_count
  );

  modport slave (
    input  start, x, y, player_black, valids, end_points, board_in,
    output board_out, busy, done, illegal, flip_count
  );
endinterface

// File: rtl/apply_move.sv
// rtl/apply_move.sv - places a disc and walks each capturing direction, flipping one cell per cycle
module apply_move (
  input  logic       clk,
  input  logic       resetn,
  apply_move_if.slave mv
);

  typedef enum logic [2:0] {S_IDLE, S_PLACE, S_SCAN, S_WALK, S_DONE} state_t;

  state_t       state_q, state_d;
  logic [2:0]   x_q, x_d, y_q, y_d;
  logic         black_q, black_d;
  logic [7:0]   valids_q, valids_d;
  logic [47:0]  end_q, end_d;
  logic [127:0] board_q, board_d;
  logic [127:0] board_out_q, board_out_d;
  logic [2:0]   dir_q, dir_d;
  logic [2:0]   dx_q, dx_d, dy_q, dy_d;
  logic [2:0]   cx_q, cx_d, cy_q, cy_d;
  logic [2:0]   step_q, step_d;
  logic [5:0]   flips_q, flips_d;
  logic         illegal_q, illegal_d;

  logic [1:0]   colour;
  logic [2:0]   scan_dir;
  logic         scan_hit;
  logic [5:0]   scan_end, walk_end;

  assign colour = black_q ? 2'b01 : 2'b10;

  // Lowest-index direction still pending.
  always_comb begin
    scan_dir = 3'd0;
    scan_hit = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (valids_q[i]) begin
        scan_dir = 3'(i);
        scan_hit = 1'b1;
      end
    end
  end

  assign scan_end = end_q[6*scan_dir +: 6];
  assign walk_end = end_q[6*dir_q +: 6];

  // -1 is encoded as 3'd7 so cursor arithmetic wraps modulo 8.
  function automatic logic [2:0] step_sign(input logic [2:0] e, input logic [2:0] o);
    if (e > o)      return 3'd1;
    else if (e < o) return 3'd7;
    else            return 3'd0;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      black_q     <= 1'b0;
      valids_q    <= '0;
      end_q       <= '0;
      board_q     <= '0;
      board_out_q <= '0;
      dir_q       <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      step_q      <= '0;
      flips_q     <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      black_q     <= black_d;
      valids_q    <= valids_d;
      end_q       <= end_d;
      board_q     <= board_d;
      board_out_q <= board_out_d;
      dir_q       <= dir_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      step_q      <= step_d;
      flips_q     <= flips_d;
      illegal_q   <= illegal_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    black_d     = black_q;
    valids_d    = valids_q;
    end_d       = end_q;
    board_d     = board_q;
    board_out_d = board_out_q;
    dir_d       = dir_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    step_d      = step_q;
    flips_d     = flips_q;
    illegal_d   = illegal_q;

    case (state_q)
      S_IDLE: begin
        if (mv.start) begin
          x_d       = mv.x;
          y_d       = mv.y;
          black_d   = mv.player_black;
          valids_d  = mv.valids;
          end_d     = mv.end_points;
          board_d   = mv.board_in;
          flips_d   = '0;
          illegal_d = (mv.valids == 8'h00);
          state_d   = (mv.valids == 8'h00) ? S_DONE : S_PLACE;
        end
      end
      S_PLACE: begin
        board_d[{y_q, x_q, 1'b0} +: 2] = colour;
        state_d = S_SCAN;
      end
      S_SCAN: begin
        if (scan_hit) begin
          dir_d   = scan_dir;
          dx_d    = step_sign(scan_end[2:0], x_q);
          dy_d    = step_sign(scan_end[5:3], y_q);
          cx_d    = x_q + dx_d;
          cy_d    = y_q + dy_d;
          step_d  = '0;
          state_d = S_WALK;
        end else begin
          state_d = S_DONE;
        end
      end
      S_WALK: begin
        // A degenerate or unreachable end point retires the direction; earlier flips stay.
        if ({cy_q, cx_q} == walk_end || walk_end == {y_q, x_q} || step_q == 3'd7) begin
          valids_d[dir_q] = 1'b0;
          state_d         = S_SCAN;
        end else begin
          board_d[{cy_q, cx_q, 1'b0} +: 2] = colour;
          flips_d = flips_q + 6'd1;
          cx_d    = cx_q + dx_q;
          cy_d    = cy_q + dy_q;
          step_d  = step_q + 3'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_DONE && state_q != S_DONE) begin
      board_out_d = board_d;
    end
  end

  always_comb begin
    mv.busy       = (state_q != S_IDLE);
    mv.done       = (state_q == S_DONE);
    mv.illegal    = illegal_q;
    mv.flip_count = flips_q;
    mv.board_out  = board_out_q;
  end

endmodule

// File: tb/tb_apply_move.sv
// tb/tb_apply_move.sv - directed self-checking bench for apply_move
module tb_apply_move;

  logic clk;
  logic resetn;
  int   checks;
  int   failures;

  apply_move_if mvif ();

  apply_move dut (
    .clk    (clk),
    .resetn (resetn),
    .mv     (mvif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] put(input logic [127:0] b, input int cx, input int cy,
                                       input logic [1:0] c);
    logic [127:0] r;
    r = b;
    r[2*(cy*8+cx) +: 2] = c;
    return r;
  endfunction

  function automatic logic [127:0] start_board();
    logic [127:0] b;
    b = '0;
    b = put(b, 3, 3, 2'b10);
    b = put(b, 4, 4, 2'b10);
    b = put(b, 3, 4, 2'b01);
    b = put(b, 4, 3, 2'b01);
    return b;
  endfunction

  task automatic drive(input logic [2:0] mx, input logic [2:0] my, input logic blk,
                       input logic [7:0] v, input logic [47:0] ep, input logic [127:0] b);
    mvif.x            = mx;
    mvif.y            = my;
    mvif.player_black = blk;
    mvif.valids       = v;
    mvif.end_points   = ep;
    mvif.board_in     = b;
  endtask

  // Returns edges after E0 at which done is first seen, or -1 on timeout.
  task automatic run_move(input logic [2:0] mx, input logic [2:0] my, input logic blk,
                          input logic [7:0] v, input logic [47:0] ep, input logic [127:0] b,
                          output int lat);
    repeat (2) @(negedge clk);
    drive(mx, my, blk, v, ep, b);
    mvif.start = 1'b1;
    @(posedge clk);
    #1;
    mvif.start = 1'b0;
    lat = 0;
    while (!mvif.done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!mvif.done) lat = -1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (mvif.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", mvif.busy); end
    checks++; if (mvif.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", mvif.done); end
    checks++; if (mvif.illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%0b exp=0", mvif.illegal); end
    checks++; if (mvif.flip_count !== 6'd0) begin failures++; $display("FAIL reset_flips got=%0d exp=0", mvif.flip_count); end
    checks++; if (mvif.board_out !== 128'd0) begin failures++; $display("FAIL reset_board got=%h exp=0", mvif.board_out); end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_single_flip();
    int lat;
    logic [47:0]  ep;
    logic [127:0] exp_b;
    ep = '0;
    ep[12 +: 6] = {3'd3, 3'd4};
    exp_b = put(put(start_board(), 2, 3, 2'b01), 3, 3, 2'b01);
    run_move(3'd2, 3'd3, 1'b1, 8'h04, ep, start_board(), lat);
    checks++; if (lat !== 5) begin failures++; $display("FAIL single_latency got=%0d exp=5", lat); end
    checks++; if (mvif.board_out !== exp_b) begin failures++; $display("FAIL single_board got=%h exp=%h", mvif.board_out, exp_b); end
    checks++; if (mvif.flip_count !== 6'd1) begin failures++; $display("FAIL single_flips got=%0d exp=1", mvif.flip_count); end
    checks++; if (mvif.illegal !== 1'b0) begin failures++; $display("FAIL single_illegal got=%0b exp=0", mvif.illegal); end
    checks++; if (mvif.busy !== 1'b1) begin failures++; $display("FAIL single_busy_done got=%0b exp=1", mvif.busy); end
    @(posedge clk);
    #1;
    checks++; if (mvif.done !== 1'b0) begin failures++; $display("FAIL single_done_pulse got=%0b exp=0", mvif.done); end
    checks++; if (mvif.busy !== 1'b0) begin failures++; $display("FAIL single_idle_busy got=%0b exp=0", mvif.busy); end
  endtask

  task automatic test_illegal();
    int lat;
    run_move(3'd2, 3'd3, 1'b1, 8'h00, 48'd0, start_board(), lat);
    checks++; if (lat !== 0) begin failures++; $display("FAIL illegal_latency got=%0d exp=0", lat); end
    checks++; if (mvif.illegal !== 1'b1) begin failures++; $display("FAIL illegal_flag got=%0b exp=1", mvif.illegal); end
    checks++; if (mvif.board_out !== start_board()) begin failures++; $display("FAIL illegal_board got=%h exp=%h", mvif.board_out, start_board()); end
    checks++; if (mvif.flip_count !== 6'd0) begin failures++; $display("FAIL illegal_flips got=%0d exp=0", mvif.flip_count); end
  endtask

  task automatic test_two_dir();
    int lat;
    logic [47:0]  ep;
    logic [127:0] b, exp_b;
    b = '0;
    b = put(b, 4, 4, 2'b01);
    b = put(b, 3, 3, 2'b01);
    b = put(b, 2, 2, 2'b10);
    b = put(b, 6, 5, 2'b01);
    b = put(b, 7, 5, 2'b10);
    ep = '0;
    ep[0 +: 6]  = {3'd2, 3'd2};
    ep[18 +: 6] = {3'd5, 3'd7};
    exp_b = put(put(put(put(b, 5, 5, 2'b10), 4, 4, 2'b10), 3, 3, 2'b10), 6, 5, 2'b10);
    run_move(3'd5, 3'd5, 1'b0, 8'b0000_1001, ep, b, lat);
    checks++; if (lat !== 9) begin failures++; $display("FAIL two_dir_latency got=%0d exp=9", lat); end
    checks++; if (mvif.board_out !== exp_b) begin failures++; $display("FAIL two_dir_board got=%h exp=%h", mvif.board_out, exp_b); end
    checks++; if (mvif.flip_count !== 6'd3) begin failures++; $display("FAIL two_dir_flips got=%0d exp=3", mvif.flip_count); end
    checks++; if (mvif.illegal !== 1'b0) begin failures++; $display("FAIL two_dir_illegal got=%0b exp=0", mvif.illegal); end
  endtask

  task automatic test_malformed();
    int lat;
    logic [47:0]  ep;
    logic [127:0] exp_b;
    ep = '0;
    ep[30 +: 6] = {3'd3, 3'd2};
    exp_b = put(start_board(), 2, 3, 2'b01);
    run_move(3'd2, 3'd3, 1'b1, 8'h20, ep, start_board(), lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL malformed_latency got=%0d exp=4", lat); end
    checks++; if (mvif.board_out !== exp_b) begin failures++; $display("FAIL malformed_board got=%h exp=%h", mvif.board_out, exp_b); end
    checks++; if (mvif.flip_count !== 6'd0) begin failures++; $display("FAIL malformed_flips got=%0d exp=0", mvif.flip_count); end
  endtask

  task automatic test_step_limit();
    int lat;
    logic [47:0]  ep;
    logic [127:0] exp_b;
    ep = '0;
    ep[6 +: 6] = {3'd6, 3'd7};
    exp_b = '0;
    for (int i = 0; i < 8; i++) exp_b = put(exp_b, i, i, 2'b10);
    run_move(3'd0, 3'd0, 1'b0, 8'h02, ep, 128'd0, lat);
    checks++; if (lat !== 11) begin failures++; $display("FAIL step_limit_latency got=%0d exp=11", lat); end
    checks++; if (mvif.board_out !== exp_b) begin failures++; $display("FAIL step_limit_board got=%h exp=%h", mvif.board_out, exp_b); end
    checks++; if (mvif.flip_count !== 6'd7) begin failures++; $display("FAIL step_limit_flips got=%0d exp=7", mvif.flip_count); end
  endtask

  task automatic test_reset_mid_move();
    int lat;
    logic [47:0]  ep;
    logic [127:0] exp_b;
    ep = '0;
    ep[0 +: 6] = {3'd0, 3'd0};
    repeat (2) @(negedge clk);
    drive(3'd5, 3'd5, 1'b0, 8'h01, ep, 128'd0);
    mvif.start = 1'b1;
    @(posedge clk);
    #1;
    mvif.start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    checks++; if (mvif.busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%0b exp=0", mvif.busy); end
    checks++; if (mvif.done !== 1'b0) begin failures++; $display("FAIL midreset_done got=%0b exp=0", mvif.done); end
    checks++; if (mvif.flip_count !== 6'd0) begin failures++; $display("FAIL midreset_flips got=%0d exp=0", mvif.flip_count); end
    checks++; if (mvif.board_out !== 128'd0) begin failures++; $display("FAIL midreset_board got=%h exp=0", mvif.board_out); end
    @(negedge clk);
    resetn = 1'b1;
    ep = '0;
    ep[12 +: 6] = {3'd3, 3'd4};
    exp_b = put(put(start_board(), 2, 3, 2'b01), 3, 3, 2'b01);
    run_move(3'd2, 3'd3, 1'b1, 8'h04, ep, start_board(), lat);
    checks++; if (lat !== 5) begin failures++; $display("FAIL midreset_restart_latency got=%0d exp=5", lat); end
    checks++; if (mvif.board_out !== exp_b) begin failures++; $display("FAIL midreset_restart_board got=%h exp=%h", mvif.board_out, exp_b); end
  endtask

  task automatic test_back_to_back();
    int lat;
    int dones;
    logic [47:0]  ep;
    logic [127:0] exp_b;
    ep = '0;
    ep[12 +: 6] = {3'd3, 3'd4};
    exp_b = put(put(start_board(), 2, 3, 2'b01), 3, 3, 2'b01);
    repeat (2) @(negedge clk);
    drive(3'd2, 3'd3, 1'b1, 8'h04, ep, start_board());
    mvif.start = 1'b1;
    @(posedge clk);
    #1;
    drive(3'd0, 3'd0, 1'b0, 8'h00, 48'd0, 128'd0);
    lat   = 0;
    dones = 0;
    while (!mvif.done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (mvif.done) dones++;
    end
    checks++; if (lat !== 5) begin failures++; $display("FAIL held_latency got=%0d exp=5", lat); end
    checks++; if (dones !== 1) begin failures++; $display("FAIL held_done_count got=%0d exp=1", dones); end
    checks++; if (mvif.board_out !== exp_b) begin failures++; $display("FAIL held_board got=%h exp=%h", mvif.board_out, exp_b); end
    checks++; if (mvif.flip_count !== 6'd1) begin failures++; $display("FAIL held_flips got=%0d exp=1", mvif.flip_count); end
    @(posedge clk);
    #1;
    checks++; if (mvif.busy !== 1'b0) begin failures++; $display("FAIL held_ignored_in_done got=%0b exp=0", mvif.busy); end
    @(posedge clk);
    #1;
    mvif.start = 1'b0;
    checks++; if (mvif.done !== 1'b1) begin failures++; $display("FAIL held_reaccept_done got=%0b exp=1", mvif.done); end
    checks++; if (mvif.illegal !== 1'b1) begin failures++; $display("FAIL held_reaccept_illegal got=%0b exp=1", mvif.illegal); end
    checks++; if (mvif.board_out !== 128'd0) begin failures++; $display("FAIL held_reaccept_board got=%h exp=0", mvif.board_out); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    resetn   = 1'b0;
    mvif.start = 1'b0;
    drive(3'd0, 3'd0, 1'b0, 8'h00, 48'd0, 128'd0);
    test_reset();
    test_single_flip();
    test_illegal();
    test_two_dir();
    test_malformed();
    test_step_limit();
    test_reset_mid_move();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
